// File: rtl/date_adjust_ctrl.sv
// date_adjust_ctrl: captures the running date, lets the user edit day/month/year with buttons, then commits
module date_adjust_ctrl #(
    parameter int TIMEOUT_TICKS = 30,
    parameter int RESET_YEAR    = 2024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        btn_mode,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic [5:0]  cur_day,
    input  logic [3:0]  cur_month,
    input  logic [13:0] cur_year,
    output logic        adjust_mode,
    output logic [5:0]  adj_day,
    output logic [3:0]  adj_month,
    output logic [13:0] adj_year,
    output logic [1:0]  field_sel
);
    typedef enum logic [2:0] {IDLE, LOAD, EDIT_DAY, EDIT_MONTH, EDIT_YEAR, COMMIT} state_t;
    localparam logic [5:0]  TO = 6'(TIMEOUT_TICKS);
    localparam logic [13:0] RY = 14'(RESET_YEAR);

    state_t      state_q, state_d;
    logic [5:0]  day_q, day_d, cnt_q, cnt_d, ld_max, cur_max;
    logic [3:0]  month_q, month_d, ld_month, m_new;
    logic [13:0] year_q, year_d, ld_year, y_new;
    logic        am_q, am_d;
    logic [1:0]  fs_q, fs_d;
    logic [2:0]  btn_q;
    logic        mode_p, up_p, down_p, any_p;

    function automatic logic [5:0] max_day(input logic [3:0] m, input logic [13:0] y);
        logic leap;
        leap = ((y % 14'd4 == 14'd0) && (y % 14'd100 != 14'd0)) || (y % 14'd400 == 14'd0);
        return (m == 4'd2) ? (leap ? 6'd29 : 6'd28) :
               (m == 4'd4 || m == 4'd6 || m == 4'd9 || m == 4'd11) ? 6'd30 : 6'd31;
    endfunction

    function automatic logic [5:0] clamp(input logic [5:0] d, input logic [5:0] md);
        return (d > md) ? md : d;
    endfunction

    assign {mode_p, up_p, down_p} = {btn_mode, btn_up, btn_down} & ~btn_q;
    assign any_p    = mode_p | up_p | down_p;
    assign ld_month = (cur_month == 4'd0 || cur_month > 4'd12) ? 4'd1 : cur_month;
    assign ld_year  = (cur_year > 14'd9999) ? 14'd0 : cur_year;
    assign ld_max   = max_day(ld_month, ld_year);
    assign cur_max  = max_day(month_q, year_q);
    assign m_new    = up_p ? ((month_q == 4'd12) ? 4'd1 : month_q + 4'd1)
                           : ((month_q == 4'd1) ? 4'd12 : month_q - 4'd1);
    assign y_new    = up_p ? ((year_q == 14'd9999) ? 14'd0 : year_q + 14'd1)
                           : ((year_q == 14'd0) ? 14'd9999 : year_q - 14'd1);

    assign adjust_mode = am_q;
    assign field_sel   = fs_q;
    assign adj_day     = day_q;
    assign adj_month   = month_q;
    assign adj_year    = year_q;

    // next state, field edits with wrap and day clamp, timeout counting, registered output decode
    always_comb begin
        state_d = state_q;
        day_d   = day_q;
        month_d = month_q;
        year_d  = year_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: state_d = mode_p ? LOAD : IDLE;
            LOAD: begin
                month_d = ld_month;
                year_d  = ld_year;
                day_d   = (cur_day == 6'd0) ? 6'd1 : clamp(cur_day, ld_max);
                cnt_d   = 6'd0;
                state_d = EDIT_DAY;
            end
            EDIT_DAY, EDIT_MONTH, EDIT_YEAR: begin
                cnt_d = any_p ? 6'd0 : (tick && cnt_q != TO) ? cnt_q + 6'd1 : cnt_q;
                if (mode_p)
                    state_d = (state_q == EDIT_DAY) ? EDIT_MONTH : (state_q == EDIT_MONTH) ? EDIT_YEAR : COMMIT;
                else if (cnt_d == TO)
                    state_d = COMMIT;
                else if (up_p ^ down_p) begin
                    if (state_q == EDIT_DAY)
                        day_d = up_p ? ((day_q >= cur_max) ? 6'd1 : day_q + 6'd1)
                                     : ((day_q <= 6'd1) ? cur_max : day_q - 6'd1);
                    else if (state_q == EDIT_MONTH) begin
                        month_d = m_new;
                        day_d   = clamp(day_q, max_day(m_new, year_q));
                    end else begin
                        year_d = y_new;
                        day_d  = clamp(day_q, max_day(month_q, y_new));
                    end
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        am_d = (state_d == EDIT_DAY || state_d == EDIT_MONTH || state_d == EDIT_YEAR || state_d == COMMIT);
        fs_d = (state_d == EDIT_DAY) ? 2'd1 : (state_d == EDIT_MONTH) ? 2'd2 : (state_d == EDIT_YEAR) ? 2'd3 : 2'd0;
    end

    // state, shadow date and button history; buttons reset high so a held button gives no edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            day_q   <= 6'd1;
            month_q <= 4'd1;
            year_q  <= RY;
            cnt_q   <= 6'd0;
            am_q    <= 1'b0;
            fs_q    <= 2'd0;
            btn_q   <= 3'b111;
        end else begin
            state_q <= state_d;
            day_q   <= day_d;
            month_q <= month_d;
            year_q  <= year_d;
            cnt_q   <= cnt_d;
            am_q    <= am_d;
            fs_q    <= fs_d;
            btn_q   <= {btn_mode, btn_up, btn_down};
        end
    end
endmodule

// File: tb/tb_date_adjust_ctrl.sv
// tb_date_adjust_ctrl: scoreboard bench with a calendar-arithmetic reference model
module tb_date_adjust_ctrl;
    localparam int TO = 3;
    logic        clk = 0, rst = 1, tick = 0, btn_mode = 0, btn_up = 0, btn_down = 0;
    logic [5:0]  cur_day = 6'd1;
    logic [3:0]  cur_month = 4'd1;
    logic [13:0] cur_year = 14'd2000;
    logic        adjust_mode;
    logic [5:0]  adj_day;
    logic [3:0]  adj_month;
    logic [13:0] adj_year;
    logic [1:0]  field_sel;

    date_adjust_ctrl #(.TIMEOUT_TICKS(TO), .RESET_YEAR(2024)) dut (
        .clk(clk), .rst(rst), .tick(tick), .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
        .cur_day(cur_day), .cur_month(cur_month), .cur_year(cur_year), .adjust_mode(adjust_mode),
        .adj_day(adj_day), .adj_month(adj_month), .adj_year(adj_year), .field_sel(field_sel)
    );

    always #5 clk = ~clk;

    typedef struct {int am; int fs; int d; int m; int y;} exp_t;
    typedef struct {exp_t mdl; bit c; exp_t k;} ent_t;
    ent_t q[$];
    int checks = 0, errors = 0;

    // model: 0 idle, 1 load, 2 day, 3 month, 4 year, 5 commit
    int ms = 0, md = 1, mm = 1, my = 2024, mcnt = 0;
    bit pm = 1, pu = 1, pd = 1;

    function automatic int dim(int m, int y);
        int t[12];
        t = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        return (m == 2 && ((y % 4 == 0 && y % 100 != 0) || y % 400 == 0)) ? 29 : t[m-1];
    endfunction

    task automatic model(bit mo, bit u, bit dn, bit tk);
        bit a, b, c;
        int n;
        a = mo && !pm; b = u && !pu; c = dn && !pd;
        pm = mo; pu = u; pd = dn;
        case (ms)
            0: if (a) ms = 1;
            1: begin
                mm = (cur_month >= 1 && cur_month <= 12) ? int'(cur_month) : 1;
                my = (cur_year <= 9999) ? int'(cur_year) : 0;
                n = dim(mm, my);
                md = (cur_day == 0) ? 1 : (int'(cur_day) > n ? n : int'(cur_day));
                mcnt = 0;
                ms = 2;
            end
            2, 3, 4: begin
                if (a || b || c) mcnt = 0;
                else if (tk && mcnt < TO) mcnt++;
                if (a) ms++;
                else if (mcnt == TO) ms = 5;
                else if (b != c) begin
                    if (ms == 2) begin
                        n = dim(mm, my);
                        md = b ? md % n + 1 : (md + n - 2) % n + 1;
                    end else begin
                        if (ms == 3) mm = b ? mm % 12 + 1 : (mm + 10) % 12 + 1;
                        else my = b ? (my + 1) % 10000 : (my + 9999) % 10000;
                        if (md > dim(mm, my)) md = dim(mm, my);
                    end
                end
            end
            default: ms = 0;
        endcase
    endtask

    task automatic drive(bit mo, bit u, bit dn, bit tk, bit c, exp_t k);
        ent_t e;
        btn_mode = mo; btn_up = u; btn_down = dn; tick = tk;
        model(mo, u, dn, tk);
        e.mdl = '{(ms >= 2) ? 1 : 0, (ms >= 2 && ms <= 4) ? ms - 1 : 0, md, mm, my};
        e.c = c;
        e.k = k;
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic step(bit mo, bit u, bit dn, bit tk);
        @(negedge clk);
        drive(mo, u, dn, tk, 0, '{0, 0, 0, 0, 0});
    endtask

    task automatic stepk(bit mo, bit u, bit dn, bit tk, int am, int fs, int d, int m, int y);
        @(negedge clk);
        drive(mo, u, dn, tk, 1, '{am, fs, d, m, y});
    endtask

    task automatic reset_dut(bit hm);
        @(negedge clk);
        rst = 0; btn_mode = hm; btn_up = 0; btn_down = 0; tick = 0;
        ms = 0; md = 1; mm = 1; my = 2024; mcnt = 0; pm = 1; pu = 1; pd = 1;
        @(negedge clk);
        rst = 1;
        drive(hm, 0, 0, 0, 0, '{0, 0, 0, 0, 0});
    endtask

    task automatic set_cur(int d, int m, int y);
        cur_day = 6'(d); cur_month = 4'(m); cur_year = 14'(y);
    endtask

    task automatic cmp(string nm, exp_t e);
        checks++;
        if (adjust_mode !== 1'(e.am) || field_sel !== 2'(e.fs) || adj_day !== 6'(e.d) ||
            adj_month !== 4'(e.m) || adj_year !== 14'(e.y)) begin
            errors++;
            $display("FAIL %s @%0t: got am=%0b fs=%0d %0d/%0d/%0d expected am=%0d fs=%0d %0d/%0d/%0d",
                     nm, $time, adjust_mode, field_sel, adj_day, adj_month, adj_year, e.am, e.fs, e.d, e.m, e.y);
        end
    endtask

    // monitor: reset values while rst is low, otherwise scoreboard entries after each edge
    initial begin
        ent_t e;
        forever begin
            @(posedge clk or negedge rst);
            #1;
            if (!rst) cmp("reset", '{0, 0, 1, 1, 2024});
            else if (q.size() > 0) begin
                e = q.pop_front();
                cmp("model", e.mdl);
                if (e.c) cmp("directed", e.k);
            end
        end
    end

    initial begin
        reset_dut(1);
        step(1, 0, 0, 0);
        stepk(1, 0, 0, 0, 0, 0, 1, 1, 2024);
        step(0, 0, 0, 0);
        set_cur(15, 6, 2025);
        stepk(1, 0, 0, 0, 0, 0, 1, 1, 2024);
        stepk(0, 0, 0, 0, 1, 1, 15, 6, 2025);

        reset_dut(0);
        set_cur(31, 1, 2024);
        step(1, 0, 0, 0);
        stepk(0, 0, 0, 0, 1, 1, 31, 1, 2024);
        stepk(0, 1, 0, 0, 1, 1, 1, 1, 2024);
        step(0, 0, 0, 0);
        stepk(0, 0, 1, 0, 1, 1, 31, 1, 2024);
        step(0, 0, 0, 0);
        stepk(0, 0, 1, 0, 1, 1, 30, 1, 2024);

        reset_dut(0);
        set_cur(31, 1, 2023);
        step(1, 0, 0, 0); step(0, 0, 0, 0);
        stepk(1, 0, 0, 0, 1, 2, 31, 1, 2023);
        step(0, 0, 0, 0);
        stepk(0, 1, 0, 0, 1, 2, 28, 2, 2023);

        reset_dut(0);
        set_cur(31, 1, 2024);
        step(1, 0, 0, 0); step(0, 0, 0, 0); step(1, 0, 0, 0); step(0, 0, 0, 0);
        stepk(0, 1, 0, 0, 1, 2, 29, 2, 2024);
        step(0, 0, 0, 0);
        stepk(1, 0, 0, 0, 1, 3, 29, 2, 2024);
        step(0, 0, 0, 0);
        stepk(0, 1, 0, 0, 1, 3, 28, 2, 2025);

        reset_dut(0);
        set_cur(10, 3, 9999);
        step(1, 0, 0, 0); step(0, 0, 0, 0); step(1, 0, 0, 0); step(0, 0, 0, 0); step(1, 0, 0, 0); step(0, 0, 0, 0);
        stepk(0, 1, 0, 0, 1, 3, 10, 3, 0);
        step(0, 0, 0, 0);
        stepk(0, 0, 1, 0, 1, 3, 10, 3, 9999);
        step(0, 0, 0, 0);
        stepk(0, 1, 1, 0, 1, 3, 10, 3, 9999);
        step(0, 0, 0, 0);
        stepk(1, 1, 0, 0, 1, 0, 10, 3, 9999);
        stepk(0, 0, 0, 0, 0, 0, 10, 3, 9999);

        reset_dut(0);
        set_cur(20, 5, 2030);
        step(1, 0, 0, 0); step(0, 0, 0, 0); step(1, 0, 0, 0); step(0, 0, 0, 0);
        step(0, 0, 0, 1); step(0, 0, 0, 1);
        stepk(0, 1, 0, 0, 1, 2, 20, 6, 2030);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        stepk(0, 0, 0, 1, 1, 2, 20, 6, 2030);
        stepk(0, 0, 0, 1, 1, 0, 20, 6, 2030);
        stepk(0, 0, 0, 0, 0, 0, 20, 6, 2030);

        reset_dut(0);
        set_cur(1, 1, 2000);
        step(1, 0, 0, 0); step(0, 0, 0, 0); step(1, 0, 0, 0); step(0, 0, 0, 0); step(1, 0, 0, 0); step(0, 0, 0, 0);
        stepk(0, 1, 0, 0, 1, 3, 1, 1, 2001);
        reset_dut(0);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                cur_day = 6'($urandom_range(0, 63));
                cur_month = 4'($urandom_range(0, 15));
                case ($urandom_range(0, 3))
                    0: cur_year = 14'($urandom_range(0, 16383));
                    1: cur_year = 14'($urandom_range(9990, 10010));
                    default: cur_year = 14'($urandom_range(1895, 2105));
                endcase
            end
            if ($urandom_range(0, 599) == 0) reset_dut(1'($urandom_range(0, 1)));
            else step($urandom_range(0, 4) == 0 ? !btn_mode : btn_mode,
                      $urandom_range(0, 4) == 0 ? !btn_up : btn_up,
                      $urandom_range(0, 4) == 0 ? !btn_down : btn_down,
                      $urandom_range(0, 1) == 0);
        end
        step(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/date_adjust_ctrl.md
Name: date_adjust_ctrl

Overview:
Button-driven configuration controller for the calendar date counter. It captures the running date into shadow registers and lets the user step through day, month and year fields with mode/up/down buttons. It drives adjust_mode and adj_day/adj_month/adj_year into the date counter, which loads them while adjust_mode is high. It also outputs the edited-field selector for the display blink logic.

Parameters:
TIMEOUT_TICKS, 30, number of tick pulses with no button edge in an edit state before auto-commit (1..63)
RESET_YEAR, 2024, adj_year value at reset

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
tick  input  1  one-clk pulse per second, used for the timeout
btn_mode  input  1  mode button level, already synchronized and debounced
btn_up  input  1  up button level, already synchronized and debounced
btn_down  input  1  down button level, already synchronized and debounced
cur_day  input  6  running day from the date counter
cur_month  input  4  running month from the date counter
cur_year  input  14  running year from the date counter
adjust_mode  output  1  high while the date counter must load adj_*
adj_day  output  6  edited day (1..max_day)
adj_month  output  4  edited month (1..12)
adj_year  output  14  edited year (0..9999)
field_sel  output  2  0 = none, 1 = day, 2 = month, 3 = year

Behaviour:
- Reset (asynchronous, rst=0): state IDLE, adjust_mode=0, adj_day=1, adj_month=1, adj_year=RESET_YEAR, field_sel=0, timeout counter=0. The button previous-value registers reset to 1, so a button held through reset release produces no edge. Reset during an edit discards the edits.
- Edge detect: each button has a registered previous value. press = btn & ~btn_prev. All outputs are registered and update on the clk edge where the press is first sampled, so the effect is visible in the following cycle.
- FSM states: IDLE, LOAD, EDIT_DAY, EDIT_MONTH, EDIT_YEAR, COMMIT.
- IDLE: adjust_mode=0, field_sel=0. A mode press goes to LOAD. Up/down presses are ignored.
- LOAD (1 cycle, adjust_mode still 0):
  - adj_* <= cur_*, sanitized: month 0 or >12 becomes 1; year >9999 becomes 0; day 0 becomes 1; day > max_day(month, year) becomes max_day.
  - Next state EDIT_DAY. Timeout counter cleared.
- EDIT_DAY/EDIT_MONTH/EDIT_YEAR: adjust_mode=1, field_sel=1/2/3.
  - Up press increments the selected field with wrap: day max_day->1, month 12->1, year 9999->0.
  - Down press decrements with wrap: day 1->max_day, month 1->12, year 0->9999.
  - Up and down pressed in the same cycle: no change.
  - Mode press advances DAY->MONTH->YEAR->COMMIT. A mode press takes priority over up/down pressed in the same cycle; the field is not changed.
- Day clamp: on any month or year change, adj_day <= min(adj_day, max_day(new_month, new_year)) in the same cycle.
- max_day: 28/29 for February (leap year = divisible by 4 and not by 100, or divisible by 400); 30 for months 4, 6, 9 and 11; 31 otherwise.
- Timeout:
  - Counter increments on each tick while in an EDIT state and clears on any button press.
  - When it reaches TIMEOUT_TICKS, go to COMMIT with edits kept.
  - The counter saturates and is cleared on entry to LOAD.
- COMMIT (1 cycle): adjust_mode=1, field_sel=0, adj_* held. Next state IDLE, where adjust_mode=0.
- Button presses in LOAD or COMMIT are ignored.
- adj_* are stable in every cycle adjust_mode=1 and change only in response to a press or clamp.

Test Plan:
- Reset, then cur=15/06/2025, press mode -> after LOAD, adjust_mode=1, field_sel=1, adj=15/06/2025.
- EDIT_DAY from 31/01/2024, up -> day=1. Down twice from day 1 -> 30.
- Day=31, month=1, year=2023, in EDIT_MONTH press up -> month=2, day clamped to 28. Same with year=2024 -> day=29. Then in EDIT_YEAR, 2024 up -> 2025, day clamped 29->28.
- EDIT_YEAR at 9999, up -> 0. Down -> 9999. Up and down pressed in the same cycle -> unchanged.
- Timeout: TIMEOUT_TICKS=3, in EDIT_MONTH apply 3 ticks with no press -> COMMIT, then IDLE with edits kept. A press between ticks restarts the count.
- Hold btn_mode high through reset release -> no edge, stays IDLE. Assert rst in EDIT_YEAR -> asynchronous return to IDLE, adj=01/01/2024.
